// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the multi-channel frequency meter.
package freq_meter_pkg;

   localparam int DEF_NUM_CH      = 4;
   localparam int DEF_CNT_W       = 40;
   localparam int DEF_GATE_W      = 32;
   localparam int DEF_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GATE  = 2'd1,
      LATCH = 2'd2
   } state_t;

   // LSB of channel ch inside a packed bus of width-bit slices
   function automatic int ch_lsb(input int ch, input int width);
      return ch * width;
   endfunction

endpackage

// File: rtl/freq_edge_sync.sv
// Input synchroniser followed by a registered rising-edge detector;
// a pin rise shows up as a one-cycle pulse SYNC_STAGES+1 cycles later.
module freq_edge_sync
   import freq_meter_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   output logic edge_pulse
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   last_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg   <= '0;
         last_reg   <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         sync_reg   <= {sync_reg[SYNC_STAGES-2:0], sig};
         last_reg   <= sync_reg[SYNC_STAGES-1];
         edge_pulse <= sync_reg[SYNC_STAGES-1] & ~last_reg;
      end
   end

endmodule

// File: rtl/freq_meter_multi.sv
// Multi-channel frequency meter: counts synchronised rising edges per channel
// over a shared gate window and offers the latched counts on valid/ready.
module freq_meter_multi
   import freq_meter_pkg::*;
#(
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int GATE_W      = DEF_GATE_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic [GATE_W-1:0]       gate_cycles,
   input  logic [NUM_CH-1:0]       sig_in,
   output logic [NUM_CH*CNT_W-1:0] count_out,
   output logic [NUM_CH-1:0]       overflow,
   output logic                    valid,
   input  logic                    ready,
   output logic                    lost,
   output logic                    gate_active
);

   state_t            state_reg, state_next;
   logic [GATE_W-1:0] gate_cnt_reg;
   logic [CNT_W-1:0]  cnt_reg [NUM_CH];
   logic [NUM_CH-1:0] ovf_reg;
   logic [NUM_CH-1:0] edge_pulse;
   logic              start_window;
   logic              gate_done;
   logic              load_window;

   assign start_window = enable && (gate_cycles != '0);
   assign gate_done    = (gate_cnt_reg == GATE_W'(1));
   assign load_window  = (state_reg != GATE) && (state_next == GATE);
   assign gate_active  = (state_reg == GATE);

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         freq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk        (clk),
            .rst_n      (rst_n),
            .sig        (sig_in[gi]),
            .edge_pulse (edge_pulse[gi])
         );
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start_window) state_next = GATE;
         GATE: begin
            // dropping enable aborts even in the final gate cycle
            if (!enable)        state_next = IDLE;
            else if (gate_done) state_next = LATCH;
         end
         LATCH:   state_next = start_window ? GATE : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         gate_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (load_window)
            gate_cnt_reg <= gate_cycles;
         else if (state_reg == GATE)
            gate_cnt_reg <= gate_cnt_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_CH; k++) cnt_reg[k] <= '0;
         ovf_reg <= '0;
      end else if (load_window) begin
         for (int k = 0; k < NUM_CH; k++) cnt_reg[k] <= '0;
         ovf_reg <= '0;
      end else if (state_reg == GATE) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (edge_pulse[k]) begin
               if (&cnt_reg[k]) ovf_reg[k] <= 1'b1;
               else             cnt_reg[k] <= cnt_reg[k] + 1'b1;
            end
         end
      end
   end

   // a fresh result takes precedence over a same-cycle handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_out <= '0;
         overflow  <= '0;
         valid     <= 1'b0;
         lost      <= 1'b0;
      end else if (state_reg == LATCH) begin
         for (int k = 0; k < NUM_CH; k++)
            count_out[ch_lsb(k, CNT_W) +: CNT_W] <= cnt_reg[k];
         overflow <= ovf_reg;
         valid    <= 1'b1;
         if (valid && !ready) lost <= 1'b1;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: doc/freq_meter_multi.md
Name: freq_meter_multi

Overview:
- Multi-channel, single-clock frequency meter. Each channel's asynchronous input is synchronised to clk, and its rising edges are counted over a common gate window of programmable length in clk cycles.
- At the end of each window, all channel counts are latched together into output registers and offered to a consumer with a valid/ready handshake.
- The meter sits between external signal pins and the readout/register logic, and runs continuous back-to-back measurements while enabled.

Parameters:
- NUM_CH, 4, number of measured input channels (1..16)
- CNT_W, 40, width of each channel edge counter and result
- GATE_W, 32, width of the gate-length input and the internal gate down-counter
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (>=2)

Ports:
- clk  input  1  measurement reference clock
- rst_n  input  1  reset, asynchronous assert, active-low
- enable  input  1  run measurements; low = idle or abort
- gate_cycles  input  GATE_W  window length in clk cycles, sampled at window start
- sig_in  input  NUM_CH  asynchronous signals to measure
- count_out  output  NUM_CH*CNT_W  latched results, channel k at bits [k*CNT_W +: CNT_W]
- overflow  output  NUM_CH  per-channel saturation flag for the latched window
- valid  output  1  a result is pending
- ready  input  1  consumer accepts the result when valid&&ready
- lost  output  1  sticky: a result was overwritten while unconsumed
- gate_active  output  1  high during GATE state

Behaviour:
- Reset: state=IDLE. count_out, overflow, valid, lost, gate_active, all counters and synchroniser flops are 0.
- Edge path per channel: SYNC_STAGES flops, then one edge register. An edge pulse appears SYNC_STAGES+1 cycles after a pin rise.
- Signal limits: input high and low times must each exceed one clk period. Faster inputs are undefined and not flagged.
- FSM states: IDLE, GATE, LATCH.
- IDLE -> GATE: when enable=1 and gate_cycles!=0.
  - Load gate_cnt=gate_cycles and clear all channel counters.
  - gate_cycles==0 keeps the FSM in IDLE.
- GATE: lasts exactly gate_cycles clk cycles.
  - Each cycle, every channel with an edge pulse increments its counter.
  - A counter at all-ones holds its value and sets that channel's internal ovf bit.
  - gate_cnt decrements each cycle. Edges in the cycle where gate_cnt==1 are counted, and the next state is LATCH.
- GATE -> IDLE (abort): when enable=0. Counters are discarded. count_out, valid and overflow are unchanged.
- LATCH: one cycle.
  - count_out<=counters, overflow<=ovf bits, valid<=1.
  - If valid was 1 and ready was 0 in this cycle, lost<=1.
  - Edge pulses in the LATCH cycle are discarded (one dead cycle per window).
  - Next state: GATE if enable=1 and gate_cycles!=0 (reload and clear as in IDLE -> GATE), otherwise IDLE.
- Handshake:
  - valid clears on the cycle after valid&&ready, unless LATCH occurs in the same cycle, in which case the new result wins and valid stays 1.
  - count_out is stable while valid=1, except when it is overwritten at LATCH.
- lost clears only on reset.
- gate_cycles changes during GATE have no effect until the next window start.
- Reset asserted mid-window clears everything immediately. No partial result is produced.
- Measured frequency = count × f_clk / gate_cycles. Quantisation is ±1 count.

Decomposition:
- Package freq_meter_pkg holds:
  - the state enum (IDLE, GATE, LATCH)
  - the channel-slice helper constant/function for count_out indexing
  - default parameter values
- Sub-module freq_edge_sync (parameter SYNC_STAGES): one synchroniser plus rising-edge detector, instantiated NUM_CH times by a generate loop.
- Counters, FSM and output registers stay in the top module.

Test Plan:
- clk 100 MHz, gate_cycles=1000, sig_in[0] period 10 clk, sig_in[1] period 25 clk, others static → after LATCH: ch0 = 100±1, ch1 = 40±1, ch2 and ch3 = 0, valid=1, overflow=0.
- CNT_W=8, gate_cycles=1000, sig_in[0] period 2 clk → ch0 = 255, overflow[0]=1, other overflow bits 0.
- Continuous run with enable=1 and ready held 0 for two windows → valid stays 1, lost=1, count_out equals the second window. Then ready=1 → valid drops next cycle, lost stays 1.
- enable dropped at cycle 500 of a 1000-cycle window → FSM returns to IDLE, valid stays 0, count_out keeps its previous value. Re-enable → a full new window starts.
- gate_cycles=0 with enable=1 → FSM stays in IDLE, gate_active=0. Set gate_cycles=5 → gate_active high for exactly 5 cycles, then one LATCH cycle, then GATE again.
- rst_n pulsed low mid-GATE with valid=1 → all outputs 0 asynchronously. After release with enable=1, the first result arrives gate_cycles+2 cycles later.
